mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported memory between two requesters: port 0 is the processor, port 1 is a loader/debug master. Both requesters and the memory use the processor's bus protocol: addr, one-cycle rstrb pulse, wmask, wdata and rdata with a fixed read latency. The arbiter adds per-port busy handshakes and uses round-robin arbitration. It sits between the processor/loader and the RAM in the SoC top.

Parameters:
XLEN, 32, data and address width
RLAT, 1, memory read latency in cycles from the mem_rstrb cycle to the cycle mem_rdata is valid; must be >= 1

Ports:
clk  in  1  clock; all logic on posedge
resetn  in  1  asynchronous active-low reset
p0_addr  in  XLEN  port 0 byte address
p0_rstrb  in  1  port 0 read request pulse
p0_wmask  in  4  port 0 byte write enables; nonzero means write request
p0_wdata  in  XLEN  port 0 write data
p0_rdata  out  XLEN  port 0 registered read data
p0_busy  out  1  port 0 request pending or in flight
p1_addr, p1_rstrb, p1_wmask, p1_wdata, p1_rdata, p1_busy  same as port 0, for port 1
mem_addr  out  XLEN  memory address
mem_rstrb  out  1  memory read strobe
mem_wmask  out  4  memory byte write enables
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data, valid RLAT cycles after mem_rstrb
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all outputs 0, pending flags cleared, state IDLE, last_grant=1 (so port 0 wins the first tie). Reset mid-transaction aborts it; no completion is reported.
- Request acceptance: a port requests when rstrb=1 or wmask!=0 while its busy=0. At the next edge the arbiter latches addr, wdata, wmask and a read/write flag into that port's pending slot, and busy rises.
- If rstrb and nonzero wmask arrive together, the request is a write; rstrb is ignored.
- A request while busy=1 is dropped and err is set. err clears only on reset.
- States: IDLE, READ (counter RLAT..0), WRITE.
- Issue rule: at an edge where the state is IDLE, or the current transaction completes:
  - choose among pending slots plus requests arriving that cycle;
  - if both ports are candidates, grant the port != last_grant;
  - load registered mem_* outputs; update last_grant; go to READ or WRITE.
- READ: mem_rstrb=1 for the first cycle only, and mem_addr is held for the whole state.
  - When the counter expires (RLAT cycles after the mem_rstrb cycle), mem_rdata is captured into pX_rdata at that edge.
  - The slot clears and busy falls next cycle, with rdata valid from then on.
- WRITE: mem_wmask/mem_wdata/mem_addr are driven for exactly one cycle. The slot clears at that edge.
- Whenever no transaction is issuing a strobe, mem_rstrb=0 and mem_wmask=0. mem_addr and mem_wdata return to 0 in IDLE.
- Uncontended timing (request in cycle 0):
  - read: mem_rstrb in cycle 1, busy high in cycles 1..1+RLAT, rdata valid from cycle 2+RLAT;
  - write: mem_wmask in cycle 1, busy falls in cycle 2.
- Back-to-back: the next pending request issues at the completion edge with no idle bubble.
- pX_rdata holds its value until that port's next read completes. Writes do not change it.
- Address alignment and byte-lane placement belong to the requester; the arbiter passes them through unchanged.

Decomposition:
- Shared package mem_bus_pkg:
  - state encodings (IDLE/READ/WRITE);
  - port index constants P_CPU=0 and P_LOAD=1;
  - the pending-slot field layout (valid, is_write, addr, wmask, wdata).
- One sub-module, mem_req_slot, instantiated per port. It holds request capture, the pending register, busy and err detection.
- The arbiter top holds the round-robin grant, the FSM/latency counter and the memory-side registers.

Test Plan:
- Port 0 read of 0x100, memory returns 0xDEADBEEF (RLAT=1) -> mem_rstrb in cycle 1 with mem_addr=0x100, p0_busy high in cycles 1-2, p0_rdata=0xDEADBEEF from cycle 3.
- Both ports read in cycle 0 (0x10 and 0x20) -> port 0 issues in cycle 1, port 1's mem_rstrb in cycle 3, p1_busy falls in cycle 5; next tie goes to port 0 again only after port 1 has been served.
- Port 1 write with wmask=0100, wdata=0x00AB0000 to 0x42 -> cycle 1 has mem_wmask=0100 and mem_addr=0x42; p1_busy falls in cycle 2; p1_rdata is unchanged.
- Continuous requests from both ports for 8 transactions -> grants strictly alternate 0,1,0,1...; no cycle has both mem_rstrb and mem_wmask active.
- RLAT=3 read, then resetn pulled low in cycle 2 -> all outputs 0 immediately; after release there are no spurious rdata updates or busy.
- Port 0 pulses rstrb again while p0_busy=1 -> the request is ignored (exactly one mem_rstrb) and err=1 until reset.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the two-port memory arbiter.
// State encodings, port indices and the pending-slot layout.
package mem_bus_pkg;

  localparam int BUS_W  = 32;
  localparam int P_CPU  = 0;
  localparam int P_LOAD = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             is_write;
    logic [BUS_W-1:0] addr;
    logic [3:0]       wmask;
    logic [BUS_W-1:0] wdata;
  } slot_t;

endpackage

// File: rtl/mem_req_slot.sv
// One requester's pending slot: capture, busy and sticky error.
// view shows the held request, or the one arriving this cycle.
module mem_req_slot
  import mem_bus_pkg::*;
#(
  parameter int XLEN = BUS_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] addr,
  input  logic            rstrb,
  input  logic [3:0]      wmask,
  input  logic [XLEN-1:0] wdata,
  input  logic            clr,
  output slot_t           view,
  output logic            busy,
  output logic            err
);

  slot_t slot;
  slot_t incoming;
  logic  req;
  logic  accept;

  assign req    = rstrb | (|wmask);
  assign accept = req & ~slot.valid;

  // A write mask wins over a simultaneous read strobe.
  always_comb begin
    incoming          = '0;
    incoming.valid    = accept;
    incoming.is_write = |wmask;
    incoming.addr     = addr;
    incoming.wmask    = wmask;
    incoming.wdata    = wdata;
  end

  assign view = slot.valid ? slot : incoming;
  assign busy = slot.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      err  <= 1'b0;
    end else begin
      if (accept)
        slot <= incoming;
      else if (clr)
        slot <= '0;
      if (req && slot.valid)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between
// the processor (port 0) and the loader/debug master (port 1).
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RLAT = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] p0_addr,
  input  logic            p0_rstrb,
  input  logic [3:0]      p0_wmask,
  input  logic [XLEN-1:0] p0_wdata,
  output logic [XLEN-1:0] p0_rdata,
  output logic            p0_busy,
  input  logic [XLEN-1:0] p1_addr,
  input  logic            p1_rstrb,
  input  logic [3:0]      p1_wmask,
  input  logic [XLEN-1:0] p1_wdata,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p1_busy,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err
);

  localparam int CW = (RLAT < 1) ? 1 : $clog2(RLAT + 1);

  slot_t           view0, view1, sel;
  logic            err0, err1;
  logic            clr0, clr1;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last_grant, active, grant;
  logic            inflight, done, issue;
  logic [1:0]      cand;
  logic [XLEN-1:0] addr_n, wdata_n;
  logic            rstrb_n;
  logic [3:0]      wmask_n;

  mem_req_slot #(.XLEN(XLEN)) u_slot0 (
    .clk   (clk),
    .rst_n (resetn),
    .addr  (p0_addr),
    .rstrb (p0_rstrb),
    .wmask (p0_wmask),
    .wdata (p0_wdata),
    .clr   (clr0),
    .view  (view0),
    .busy  (p0_busy),
    .err   (err0)
  );

  mem_req_slot #(.XLEN(XLEN)) u_slot1 (
    .clk   (clk),
    .rst_n (resetn),
    .addr  (p1_addr),
    .rstrb (p1_rstrb),
    .wmask (p1_wmask),
    .wdata (p1_wdata),
    .clr   (clr1),
    .view  (view1),
    .busy  (p1_busy),
    .err   (err1)
  );

  assign err      = err0 | err1;
  assign inflight = (state != S_IDLE);
  assign done     = (state == S_READ && cnt == '0)
                  || (state == S_WRITE);
  assign clr0     = done & ~active;
  assign clr1     = done & active;

  // The in-flight port's slot is not a candidate for reissue.
  assign cand[0] = view0.valid & ~(inflight & ~active);
  assign cand[1] = view1.valid & ~(inflight & active);
  assign grant   = (&cand) ? ~last_grant : cand[1];
  assign sel     = grant ? view1 : view0;
  assign issue   = (!inflight || done) && (|cand) && sel.valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= 1'(P_LOAD);
      active     <= 1'(P_CPU);
      mem_addr   <= '0;
      mem_rstrb  <= 1'b0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_addr  <= addr_n;
      mem_rstrb <= rstrb_n;
      mem_wmask <= wmask_n;
      mem_wdata <= wdata_n;
      if (issue) begin
        last_grant <= grant;
        active     <= grant;
      end
      if (state == S_READ && cnt == '0) begin
        if (active)
          p1_rdata <= mem_rdata;
        else
          p0_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == S_READ && cnt != '0)
      cnt_n = cnt - 1'b1;
    if (!inflight || done) begin
      state_n = S_IDLE;
      if (issue) begin
        state_n = sel.is_write ? S_WRITE : S_READ;
        cnt_n   = CW'(RLAT);
      end
    end
  end

  always_comb begin
    addr_n  = mem_addr;
    rstrb_n = 1'b0;
    wmask_n = '0;
    wdata_n = '0;
    if (issue) begin
      addr_n  = sel.addr;
      rstrb_n = ~sel.is_write;
      wmask_n = sel.is_write ? sel.wmask : 4'b0;
      wdata_n = sel.is_write ? sel.wdata : '0;
    end else if (state_n == S_IDLE) begin
      addr_n = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: RLAT=1 instance with queued
// expectations, plus an RLAT=3 instance for latency and reset.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn, q_resetn;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        p0_rstrb, p1_rstrb, p0_busy, p1_busy;
  logic [3:0]  p0_wmask, p1_wmask;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rstrb, err;
  logic [3:0]  m_wmask;

  logic [31:0] q_p0_addr, q_p0_rdata, q_p1_rdata;
  logic        q_p0_rstrb, q_p0_busy, q_p1_busy;
  logic [31:0] q_m_addr, q_m_wdata, q_m_rdata;
  logic        q_m_rstrb, q_err;
  logic [3:0]  q_m_wmask;
  logic [31:0] q_zero32 = '0;
  logic [3:0]  q_zero4  = '0;
  logic        q_zero1  = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        rs;
    logic [3:0]  wm;
    logic [31:0] wd;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } cmp_t;

  iss_t iq[$];
  cmp_t cq0[$];
  cmp_t cq1[$];

  mem_arbiter #(.XLEN(32), .RLAT(1)) u1 (
    .clk(clk), .resetn(resetn),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wmask(p0_wmask),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_busy(p0_busy),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wmask(p1_wmask),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_busy(p1_busy),
    .mem_addr(m_addr), .mem_rstrb(m_rstrb), .mem_wmask(m_wmask),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata), .err(err)
  );

  mem_arbiter #(.XLEN(32), .RLAT(3)) u3 (
    .clk(clk), .resetn(q_resetn),
    .p0_addr(q_p0_addr), .p0_rstrb(q_p0_rstrb), .p0_wmask(q_zero4),
    .p0_wdata(q_zero32), .p0_rdata(q_p0_rdata), .p0_busy(q_p0_busy),
    .p1_addr(q_zero32), .p1_rstrb(q_zero1), .p1_wmask(q_zero4),
    .p1_wdata(q_zero32), .p1_rdata(q_p1_rdata), .p1_busy(q_p1_busy),
    .mem_addr(q_m_addr), .mem_rstrb(q_m_rstrb), .mem_wmask(q_m_wmask),
    .mem_wdata(q_m_wdata), .mem_rdata(q_m_rdata), .err(q_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  // RAM models: data valid exactly RLAT cycles after the strobe.
  logic        v1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [2:0]  v3 = '0;
  logic [31:0] a3 [3];
  always @(posedge clk) begin
    v1 <= m_rstrb;
    a1 <= m_addr;
    v3 <= {v3[1:0], q_m_rstrb};
    a3[0] <= q_m_addr;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign m_rdata   = v1 ? memf(a1) : 32'hBAD0BAD0;
  assign q_m_rdata = v3[2] ? memf(a3[2]) : 32'hBAD0BAD0;

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic exp_iss(input int cy, input logic [31:0] a,
                         input logic rs, input logic [3:0] wm,
                         input logic [31:0] wd);
    iss_t e;
    e.cyc = cy; e.addr = a; e.rs = rs; e.wm = wm; e.wd = wd;
    iq.push_back(e);
  endtask

  task automatic exp_cmp(input int port, input int cy,
                         input logic [31:0] rd);
    cmp_t e;
    e.cyc = cy; e.rd = rd;
    if (port == 0) cq0.push_back(e);
    else cq1.push_back(e);
  endtask

  // Monitor: memory-side issues and busy-fall completions.
  logic pb0 = 1'b0, pb1 = 1'b0;
  always @(negedge clk) begin
    iss_t e;
    cmp_t k;
    if (m_rstrb || m_wmask != 0) begin
      if (iq.size() == 0) begin
        checks++; failures++;
        $display("FAIL issue_unexpected cyc=%0d addr=%h", cyc, m_addr);
      end else begin
        e = iq.pop_front();
        chk("issue", 160'({16'(cyc), m_addr, m_rstrb, m_wmask, m_wdata}),
            160'({16'(e.cyc), e.addr, e.rs, e.wm, e.wd}));
      end
    end
    if (pb0 && !p0_busy) begin
      if (cq0.size() == 0) begin
        checks++; failures++;
        $display("FAIL p0_done_unexpected cyc=%0d", cyc);
      end else begin
        k = cq0.pop_front();
        chk("p0_done", 160'({16'(cyc), p0_rdata}),
            160'({16'(k.cyc), k.rd}));
      end
    end
    if (pb1 && !p1_busy) begin
      if (cq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL p1_done_unexpected cyc=%0d", cyc);
      end else begin
        k = cq1.pop_front();
        chk("p1_done", 160'({16'(cyc), p1_rdata}),
            160'({16'(k.cyc), k.rd}));
      end
    end
    pb0 = p0_busy;
    pb1 = p1_busy;
  end

  initial begin
    int c, n0, n1;
    logic any;
    resetn = 1'b0; q_resetn = 1'b0;
    p0_addr = '0; p0_rstrb = 0; p0_wmask = '0; p0_wdata = '0;
    p1_addr = '0; p1_rstrb = 0; p1_wmask = '0; p1_wdata = '0;
    q_p0_addr = '0; q_p0_rstrb = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 160'({p0_rdata, p1_rdata, m_addr, m_wdata,
        m_rstrb, m_wmask, p0_busy, p1_busy, err}), '0);
    resetn = 1'b1; q_resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Tie from reset: port 0 first, port 1 two cycles later.
    c = cyc;
    p0_addr = 32'h10; p0_rstrb = 1;
    p1_addr = 32'h20; p1_rstrb = 1;
    exp_iss(c + 1, 32'h10, 1, 4'h0, 0);
    exp_iss(c + 3, 32'h20, 1, 4'h0, 0);
    exp_cmp(0, c + 3, memf(32'h10));
    exp_cmp(1, c + 5, memf(32'h20));
    @(negedge clk);
    p0_rstrb = 0; p1_rstrb = 0;
    repeat (6) @(negedge clk);

    // Single port-0 read of 0x100.
    c = cyc;
    p0_addr = 32'h100; p0_rstrb = 1;
    exp_iss(c + 1, 32'h100, 1, 4'h0, 0);
    exp_cmp(0, c + 3, 32'hDEADBEEF);
    @(negedge clk);
    p0_rstrb = 0;
    repeat (5) @(negedge clk);

    // Port-1 byte write; rdata must stay at the old read value.
    c = cyc;
    p1_addr = 32'h42; p1_wmask = 4'b0100; p1_wdata = 32'h00AB0000;
    p1_rstrb = 1;
    exp_iss(c + 1, 32'h42, 0, 4'b0100, 32'h00AB0000);
    exp_cmp(1, c + 2, memf(32'h20));
    @(negedge clk);
    p1_rstrb = 0; p1_wmask = '0; p1_wdata = '0;
    repeat (5) @(negedge clk);

    // Continuous load: strict alternation, no idle bubble.
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      exp_iss(c + 1 + 2 * k,
              ((k % 2) == 0 ? 32'h200 : 32'h300) + 32'(4 * (k / 2)),
              1, 4'h0, 0);
      exp_cmp(k % 2, c + 3 + 2 * k,
              memf(((k % 2) == 0 ? 32'h200 : 32'h300) + 32'(4 * (k / 2))));
    end
    n0 = 0; n1 = 0;
    repeat (22) begin
      p0_rstrb = !p0_busy && n0 < 4;
      if (p0_rstrb) begin p0_addr = 32'h200 + 32'(4 * n0); n0++; end
      p1_rstrb = !p1_busy && n1 < 4;
      if (p1_rstrb) begin p1_addr = 32'h300 + 32'(4 * n1); n1++; end
      @(negedge clk);
    end
    p0_rstrb = 0; p1_rstrb = 0;
    repeat (3) @(negedge clk);

    // Request while busy is dropped and sets sticky err.
    chk("err_clear_before", 160'(err), 160'(0));
    c = cyc;
    p0_addr = 32'h80; p0_rstrb = 1;
    exp_iss(c + 1, 32'h80, 1, 4'h0, 0);
    exp_cmp(0, c + 3, memf(32'h80));
    @(negedge clk);
    p0_addr = 32'h84; p0_rstrb = 1;
    @(negedge clk);
    p0_rstrb = 0;
    chk("err_set", 160'(err), 160'(1));
    repeat (6) @(negedge clk);
    chk("err_sticky", 160'(err), 160'(1));
    chk("iq_drained", 160'(iq.size()), 160'(0));
    chk("cq0_drained", 160'(cq0.size()), 160'(0));
    chk("cq1_drained", 160'(cq1.size()), 160'(0));
    resetn = 1'b0;
    #1;
    chk("reset_clears", 160'({err, p0_rdata, p1_rdata}), '0);
    @(negedge clk);
    resetn = 1'b1;

    // RLAT=3: busy for 4 cycles, rdata valid from cycle 5.
    c = cyc;
    q_p0_addr = 32'h100; q_p0_rstrb = 1;
    @(negedge clk);
    q_p0_rstrb = 0;
    chk("q_issue", 160'({q_m_rstrb, q_m_addr, q_p0_busy}),
        160'({1'b1, 32'h100, 1'b1}));
    repeat (3) @(negedge clk);
    chk("q_c4", 160'({q_p0_busy, q_m_rstrb, q_p0_rdata}),
        160'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    chk("q_c5", 160'({q_p0_busy, q_p0_rdata}),
        160'({1'b0, 32'hDEADBEEF}));
    repeat (2) @(negedge clk);

    // Reset two cycles into a read aborts it.
    q_p0_addr = 32'h20; q_p0_rstrb = 1;
    @(negedge clk);
    q_p0_rstrb = 0;
    @(negedge clk);
    q_resetn = 1'b0;
    #1;
    chk("q_reset_outs", 160'({q_p0_rdata, q_p1_rdata, q_m_addr,
        q_m_wdata, q_m_rstrb, q_m_wmask, q_p0_busy, q_p1_busy, q_err}),
        '0);
    repeat (2) @(negedge clk);
    q_resetn = 1'b1;
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | q_p0_busy | q_m_rstrb | (q_p0_rdata != 0);
    end
    chk("q_no_spurious", 160'(any), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
